// File: rtl/s3_csee.sv
// Chien search and Forney error evaluator for a t=2 Reed-Solomon decoder over GF(2^8) (poly 0x11D).
// Scans positions N-1 down to 0, one per cycle, and emits the error magnitude at each position.
module s3_csee #(
    parameter int N = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       csee_ena,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       out_vld,
    output logic       out_sop,
    output logic       out_eop,
    output logic [7:0] out_pos,
    output logic [7:0] out_err,
    output logic       csee_done,
    output logic       csee_fail,
    output logic [1:0] err_cnt
);

    // state | meaning
    // IDLE  | waiting for csee_ena; coefficients captured on the start edge
    // LOAD  | compute inv(lambda1) and the alpha^-(N-1) start terms
    // SCAN  | evaluate one position per cycle, i = N-1 .. 0
    // DONE  | publish err_cnt / csee_fail with the csee_done pulse
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        SCAN = 4'b0100,
        DONE = 4'b1000
    } state_t;

    function automatic logic [7:0] gf2m8_multi(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; 0 maps to 0 naturally
    function automatic logic [7:0] gf2m8_inverse(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf2m8_multi(p, p);
            r = gf2m8_multi(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < e; k++) r = gf2m8_multi(r, 8'h02);
        return r;
    endfunction

    localparam logic [7:0] A_NEG1_START = gf_pow((256 - N) % 255);
    localparam logic [7:0] A_NEG2_START = gf_pow((2 * (256 - N)) % 255);
    localparam logic [7:0] A_POS_START  = gf_pow(N - 1);
    localparam logic [7:0] POS_FIRST    = 8'(N - 1);
    localparam logic [7:0] ALPHA_INV    = 8'h8E;

    state_t     state_q, state_d;
    logic [7:0] lam0, lam1, lam2, om0, om1;
    logic [7:0] inv_l1, t1, t2, o1, ai, cnt;
    logic [1:0] root_cnt, deg;
    logic [7:0] lam_eval, err_val;
    logic       is_root;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        lam_eval = lam0 ^ t1 ^ t2;
        is_root  = (lam_eval == 8'h00);
        err_val  = 8'h00;
        deg      = (lam2 != 8'h00) ? 2'd2 : ((lam1 != 8'h00) ? 2'd1 : 2'd0);
        if (is_root) err_val = gf2m8_multi(gf2m8_multi(ai, om0 ^ o1), inv_l1);
        case (state_q)
            IDLE:    if (csee_ena) state_d = LOAD;
            LOAD:    state_d = SCAN;
            SCAN:    if (cnt == 8'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lam0 <= '0; lam1 <= '0; lam2 <= '0; om0 <= '0; om1 <= '0;
            inv_l1 <= '0; t1 <= '0; t2 <= '0; o1 <= '0; ai <= '0;
            cnt <= '0; root_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: if (csee_ena) begin
                    lam0 <= rs_lambda0; lam1 <= rs_lambda1; lam2 <= rs_lambda2;
                    om0  <= rs_omega0;  om1  <= rs_omega1;
                    root_cnt <= 2'd0;
                end
                LOAD: begin
                    inv_l1 <= gf2m8_inverse(lam1);
                    t1     <= gf2m8_multi(lam1, A_NEG1_START);
                    t2     <= gf2m8_multi(lam2, A_NEG2_START);
                    o1     <= gf2m8_multi(om1, A_NEG1_START);
                    ai     <= A_POS_START;
                    cnt    <= POS_FIRST;
                end
                SCAN: begin
                    // i decreases, so alpha^-i terms grow by alpha and alpha^i shrinks by alpha^-1
                    t1  <= gf2m8_multi(t1, 8'h02);
                    t2  <= gf2m8_multi(t2, 8'h04);
                    o1  <= gf2m8_multi(o1, 8'h02);
                    ai  <= gf2m8_multi(ai, ALPHA_INV);
                    cnt <= cnt - 8'd1;
                    if (is_root && root_cnt != 2'd3) root_cnt <= root_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld <= 1'b0; out_sop <= 1'b0; out_eop <= 1'b0;
            out_pos <= '0; out_err <= '0;
            csee_done <= 1'b0; csee_fail <= 1'b0; err_cnt <= '0;
        end else begin
            out_vld   <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_pos   <= '0;
            out_err   <= '0;
            csee_done <= 1'b0;
            if (state_q == SCAN) begin
                out_vld <= 1'b1;
                out_sop <= (cnt == POS_FIRST);
                out_eop <= (cnt == 8'd0);
                out_pos <= cnt;
                out_err <= err_val;
            end
            if (state_q == DONE) begin
                csee_done <= 1'b1;
                err_cnt   <= root_cnt;
                csee_fail <= (root_cnt != deg) || (lam0 == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_s3_csee.sv
// Scoreboard bench for s3_csee: stimulus pushes expected scan/done records, a monitor pops and compares.
module tb_s3_csee;
    localparam int N = 255;

    logic       clk = 1'b0;
    logic       rstn;
    logic       csee_ena;
    logic [7:0] rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1;
    logic       out_vld, out_sop, out_eop, csee_done, csee_fail;
    logic [7:0] out_pos, out_err;
    logic [1:0] err_cnt;

    s3_csee #(.N(N)) dut (
        .clk(clk), .rstn(rstn), .csee_ena(csee_ena),
        .rs_lambda0(rs_lambda0), .rs_lambda1(rs_lambda1), .rs_lambda2(rs_lambda2),
        .rs_omega0(rs_omega0), .rs_omega1(rs_omega1),
        .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop),
        .out_pos(out_pos), .out_err(out_err),
        .csee_done(csee_done), .csee_fail(csee_fail), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pos;
        logic [7:0] err;
        logic       sop;
        logic       eop;
        int         cyc;
    } out_t;

    typedef struct {
        logic [1:0] cnt;
        logic       fail;
        int         cyc;
    } done_t;

    out_t  oq[$];
    done_t dq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    vld_seen = 0;
    int    done_seen = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        out_t  e;
        done_t d;
        if (rstn) begin
            if (out_vld) begin
                n_cmp++;
                if (oq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_vld: got pos=%0d err=%02h at cycle %0d, expected no output", out_pos, out_err, cyc);
                end else begin
                    e = oq.pop_front();
                    if (out_pos !== e.pos || out_err !== e.err || out_sop !== e.sop || out_eop !== e.eop || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL scan_out: got pos=%0d err=%02h sop=%b eop=%b cyc=%0d, expected pos=%0d err=%02h sop=%b eop=%b cyc=%0d",
                                 out_pos, out_err, out_sop, out_eop, cyc, e.pos, e.err, e.sop, e.eop, e.cyc);
                    end
                end
                vld_seen++;
            end else begin
                n_cmp++;
                if (out_pos !== 8'h00 || out_err !== 8'h00 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_zero: got pos=%0d err=%02h sop=%b eop=%b, expected all 0", out_pos, out_err, out_sop, out_eop);
                end
            end
            if (csee_done) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: at cycle %0d, expected no csee_done", cyc);
                end else begin
                    d = dq.pop_front();
                    if (err_cnt !== d.cnt || csee_fail !== d.fail || cyc != d.cyc) begin
                        n_bad++;
                        $display("FAIL done_status: got cnt=%0d fail=%b cyc=%0d, expected cnt=%0d fail=%b cyc=%0d",
                                 err_cnt, csee_fail, cyc, d.cnt, d.fail, d.cyc);
                    end
                end
                done_seen++;
            end
        end
    end

    task automatic start(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                         input logic [7:0] o0, input logic [7:0] o1, output int t);
        @(negedge clk);
        rs_lambda0 = l0; rs_lambda1 = l1; rs_lambda2 = l2;
        rs_omega0 = o0;  rs_omega1 = o1;
        csee_ena = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        csee_ena = 1'b0;
        rs_lambda0 = 8'hA5; rs_lambda1 = 8'h3C; rs_lambda2 = 8'h77;
        rs_omega0 = 8'hE1;  rs_omega1 = 8'h19;
    endtask

    task automatic push_scan(input int t, input int pa, input logic [7:0] ea,
                             input int pb, input logic [7:0] eb, input int n_out,
                             input bit with_done, input logic [1:0] cnt, input logic fail);
        out_t  e;
        done_t d;
        for (int k = 0; k < n_out; k++) begin
            e.pos = 8'(N - 1 - k);
            e.err = ((N - 1 - k) == pa) ? ea : (((N - 1 - k) == pb) ? eb : 8'h00);
            e.sop = (k == 0);
            e.eop = ((N - 1 - k) == 0);
            e.cyc = t + 2 + k;
            oq.push_back(e);
        end
        if (with_done) begin
            d.cnt = cnt; d.fail = fail; d.cyc = t + N + 2;
            dq.push_back(d);
        end
    endtask

    task automatic wait_done(input string name);
        int target;
        int k;
        target = done_seen + 1;
        k = 0;
        while (done_seen < target && k < N + 50) begin
            @(posedge clk);
            k++;
        end
        if (done_seen < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no csee_done in %0d cycles, expected one", name, k);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if (out_vld !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_pos !== 8'h00 || out_err !== 8'h00 ||
            csee_done !== 1'b0 || csee_fail !== 1'b0 || err_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got vld=%b sop=%b eop=%b pos=%02h err=%02h done=%b fail=%b cnt=%0d, expected all 0",
                     name, out_vld, out_sop, out_eop, out_pos, out_err, csee_done, csee_fail, err_cnt);
        end
    endtask

    initial begin
        int t;
        int k;
        int target;
        rstn = 1'b0;
        csee_ena = 1'b0;
        rs_lambda0 = 8'h00; rs_lambda1 = 8'h00; rs_lambda2 = 8'h00;
        rs_omega0 = 8'h00;  rs_omega1 = 8'h00;
        #1;
        check_all_zero("reset_state");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // no errors
        start(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, t);
        push_scan(t, -1, 8'h00, -1, 8'h00, N, 1'b1, 2'd0, 1'b0);
        wait_done("no_err");

        // single error at position 3
        start(8'h01, 8'h08, 8'h00, 8'h5A, 8'h00, t);
        push_scan(t, 3, 8'h5A, -1, 8'h00, N, 1'b1, 2'd1, 1'b0);
        wait_done("single");

        // double error at positions 1 and 0, with a stray csee_ena mid-scan
        start(8'h01, 8'h03, 8'h02, 8'h00, 8'h03, t);
        push_scan(t, 1, 8'h01, 0, 8'h01, N, 1'b1, 2'd2, 1'b0);
        repeat (50) @(negedge clk);
        rs_lambda0 = 8'h01; rs_lambda1 = 8'h08; rs_lambda2 = 8'h00; rs_omega0 = 8'h5A;
        csee_ena = 1'b1;
        @(negedge clk);
        csee_ena = 1'b0;
        wait_done("double_midena");

        // double root: lambda1 = 0 so magnitude is 0, root still counted, degree mismatch
        start(8'h01, 8'h00, 8'h01, 8'h5A, 8'h11, t);
        push_scan(t, 0, 8'h00, -1, 8'h00, N, 1'b1, 2'd1, 1'b1);
        wait_done("double_root");

        // lambda0 == 0: no roots, flagged
        start(8'h00, 8'h01, 8'h00, 8'h22, 8'h00, t);
        push_scan(t, -1, 8'h00, -1, 8'h00, N, 1'b1, 2'd0, 1'b1);
        wait_done("lam0_zero");

        // all-zero locator: every position is a root, count saturates
        start(8'h00, 8'h00, 8'h00, 8'h33, 8'h44, t);
        push_scan(t, -1, 8'h00, -1, 8'h00, N, 1'b1, 2'd3, 1'b1);
        wait_done("saturate");

        // reset after 100 scan outputs
        start(8'h01, 8'h08, 8'h00, 8'h5A, 8'h00, t);
        push_scan(t, 3, 8'h5A, -1, 8'h00, 100, 1'b0, 2'd0, 1'b0);
        target = vld_seen + 100;
        k = 0;
        while (vld_seen < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (vld_seen < target) begin
            n_bad++;
            $display("FAIL pre_reset_scan: got %0d outputs, expected %0d", vld_seen - (target - 100), 100);
        end
        rstn = 1'b0;
        #1;
        check_all_zero("mid_scan_reset");
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (oq.size() != 0 || dq.size() != 0) begin
            n_bad++;
            $display("FAIL reset_queue: got %0d/%0d pending, expected 0/0", oq.size(), dq.size());
        end

        // clean full scan after reset
        start(8'h01, 8'h08, 8'h00, 8'h5A, 8'h00, t);
        push_scan(t, 3, 8'h5A, -1, 8'h00, N, 1'b1, 2'd1, 1'b0);
        wait_done("post_reset");
        repeat (3) @(negedge clk);

        n_cmp++;
        if (oq.size() != 0 || dq.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue: got %0d/%0d pending, expected 0/0", oq.size(), dq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/s3_csee.md
S3_CSEE -- requirements
Module: s3_csee

Interface
REQ-001 Parameter N, default 255, codeword length in symbols; legal range 5..255.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 csee_ena  input  1  one-cycle start pulse; driven by KES kes_done.
REQ-005 rs_lambda0/1/2  input  8 each  error-locator coefficients, valid in the csee_ena cycle only.
REQ-006 rs_omega0/1  input  8 each  error-evaluator coefficients, valid in the csee_ena cycle only.
REQ-007 out_vld  output  1  one result per cycle during scan.
REQ-008 out_sop / out_eop  output  1 each  first / last scan cycle.
REQ-009 out_pos  output  8  symbol position i (coefficient of x^i).
REQ-010 out_err  output  8  error magnitude at out_pos; 0x00 = no error.
REQ-011 csee_done  output  1  one-cycle pulse after the last scan cycle.
REQ-012 csee_fail  output  1  uncorrectable flag, valid with csee_done.
REQ-013 err_cnt  output  2  roots found, valid with csee_done.

Function
REQ-014 Arithmetic: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02; use the codebase gf2m8_multi and gf2m8_inverse; inverse of 0x00 yields 0x00.
REQ-015 FSM one-hot: IDLE -> LOAD on csee_ena; LOAD -> SCAN after 1 cycle; SCAN -> DONE after N cycles; DONE -> IDLE after 1 cycle.
REQ-016 csee_ena outside IDLE: ignored; no effect on the scan in progress.
REQ-017 Inputs captured at the csee_ena edge (T); LOAD computes inv(lambda1) and the start-position terms.
REQ-018 Scan order: descending, i = N-1 down to 0, one position per cycle.
REQ-019 Timing: out_vld high for cycles T+2 .. T+N+1; out_sop at T+2 with out_pos=N-1; out_eop at T+N+1 with out_pos=0; csee_done at T+N+2.
REQ-020 Chien: Lambda(alpha^-i) = lambda0 ^ lambda1*alpha^-i ^ lambda2*alpha^-2i.
REQ-021 Chien registers: initialise with the alpha^-(N-1) / alpha^-2(N-1) terms (constants derived from N); step by *alpha / *alpha^2 each cycle; no per-cycle exponentiation.
REQ-022 Root at i (Lambda(alpha^-i)==0): out_err = alpha^i * (omega0 ^ omega1*alpha^-i) * inv(lambda1) (Forney, first consecutive root 0, Lambda' = lambda1); otherwise out_err=0x00.
REQ-023 lambda1==0 with a root: out_err=0x00; the root is counted.
REQ-024 deg(Lambda): 2 if lambda2!=0; else 1 if lambda1!=0; else 0.
REQ-025 err_cnt saturates at 3.
REQ-026 csee_fail=1 iff root count != deg(Lambda), or lambda0==0.
REQ-027 err_cnt and csee_fail hold until the next csee_done.
REQ-028 Outputs registered; out_pos/out_err = 0 when out_vld=0.

Reset
REQ-029 On rstn low, at any time including mid-scan: FSM->IDLE; every output and internal register = 0 immediately; no further out_vld until a new csee_ena after release.

Verification
REQ-030 No errors: lambda=(01,00,00), omega=(00,00) -> 255 out_vld cycles, all out_err=00, csee_done with err_cnt=0, fail=0.
REQ-031 Single error: lambda=(01,08,00), omega=(5A,00) -> out_err=5A at out_pos=3 only, err_cnt=1, fail=0.
REQ-032 Double error: lambda=(01,03,02), omega=(00,03) -> out_err=01 at out_pos=1 and 0 (last two cycles, out_eop on pos 0), err_cnt=2, fail=0.
REQ-033 Double root: lambda=(01,00,01) -> one root at pos 0 with out_err=00, err_cnt=1, fail=1.
REQ-034 csee_ena pulsed mid-scan -> ignored, scan finishes at T+N+1. Reset at scan cycle 100 -> all outputs 0. Next csee_ena -> clean full scan.
